// File: rtl/kim_panel_responder.sv
// KIM-1 front-panel responder: answers keypad row scans for a host-injected key
// and captures the multiplexed 7-segment display into six decaying digit registers.
module kim_panel_responder #(
  parameter int unsigned HOLD_SCANS    = 4,
  parameter int unsigned RELEASE_SCANS = 4,
  parameter int unsigned PHASE_TIMEOUT = 1_000_000,
  parameter int unsigned SETTLE        = 4,
  parameter int unsigned DECAY         = 2_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  kb_row,
  output logic [6:0]  kb_col,
  input  logic [5:0]  led_dig,
  input  logic [6:0]  led_seg,
  input  logic [4:0]  key_code,
  input  logic        key_valid,
  output logic        key_ready,
  output logic        key_busy,
  output logic [41:0] disp,
  output logic        disp_update
);

  localparam int unsigned SCAN_MAX = (HOLD_SCANS > RELEASE_SCANS) ? HOLD_SCANS : RELEASE_SCANS;
  localparam int unsigned SW  = $clog2(SCAN_MAX + 1);
  localparam int unsigned TW  = $clog2(PHASE_TIMEOUT + 1);
  localparam int unsigned STW = $clog2(SETTLE + 1);
  localparam int unsigned DW  = $clog2(DECAY + 1);
  localparam int unsigned NDIG = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_RELEASE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] scan_q, scan_d, scan_dec;
  logic [TW-1:0] tmo_q, tmo_d, tmo_dec;
  logic [1:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic [3:0]    kb_row_q, kb_row_prev_q;
  logic          scan_tick;

  // A scan starts when the scanner first lands on row 0.
  assign scan_tick = (kb_row_q == 4'b1110) && (kb_row_prev_q != 4'b1110);
  assign scan_dec  = (scan_tick && (scan_q != '0)) ? scan_q - SW'(1) : scan_q;
  assign tmo_dec   = (tmo_q != '0) ? tmo_q - TW'(1) : tmo_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      scan_q        <= '0;
      tmo_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      kb_row_q      <= 4'hF;
      kb_row_prev_q <= 4'hF;
    end else begin
      state_q       <= state_d;
      scan_q        <= scan_d;
      tmo_q         <= tmo_d;
      row_q         <= row_d;
      col_q         <= col_d;
      kb_row_q      <= kb_row;
      kb_row_prev_q <= kb_row_q;
    end
  end

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    tmo_d   = tmo_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid && (key_code <= 5'd20)) begin
          state_d = ST_PRESS;
          scan_d  = SW'(HOLD_SCANS);
          tmo_d   = TW'(PHASE_TIMEOUT);
          if (key_code < 5'd7) begin
            row_d = 2'd0;
            col_d = key_code[2:0];
          end else if (key_code < 5'd14) begin
            row_d = 2'd1;
            col_d = 3'(key_code - 5'd7);
          end else begin
            row_d = 2'd2;
            col_d = 3'(key_code - 5'd14);
          end
        end
      end
      ST_PRESS: begin
        scan_d = scan_dec;
        tmo_d  = tmo_dec;
        if ((scan_dec == '0) || (tmo_dec == '0)) begin
          state_d = ST_RELEASE;
          scan_d  = SW'(RELEASE_SCANS);
          tmo_d   = TW'(PHASE_TIMEOUT);
        end
      end
      ST_RELEASE: begin
        scan_d = scan_dec;
        tmo_d  = tmo_dec;
        if ((scan_dec == '0) || (tmo_dec == '0)) begin
          state_d = ST_IDLE;
          scan_d  = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Column answer is combinational: the CPU reads it in the same bus cycle it selects the row.
  always_comb begin
    key_ready = (state_q == ST_IDLE);
    key_busy  = (state_q != ST_IDLE);
    kb_col    = 7'h7F;
    if ((state_q == ST_PRESS) && (kb_row == ~(4'b0001 << row_q)))
      kb_col = ~(7'b000_0001 << col_q);
  end

  logic [12:0]          pair_q;
  logic [STW-1:0]       stab_q, stab_d;
  logic [NDIG-1:0][6:0] dig_q, dig_d;
  logic [DW-1:0]        dcy_q [NDIG];
  logic [DW-1:0]        dcy_d [NDIG];
  logic                 upd_q, upd_d;
  logic [2:0]           sel_idx;
  logic                 onehot, settled, wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair_q <= '0;
      stab_q <= '0;
      dig_q  <= '0;
      upd_q  <= 1'b0;
      for (int i = 0; i < NDIG; i++) dcy_q[i] <= '0;
    end else begin
      pair_q <= {led_dig, led_seg};
      stab_q <= stab_d;
      dig_q  <= dig_d;
      upd_q  <= upd_d;
      for (int i = 0; i < NDIG; i++) dcy_q[i] <= dcy_d[i];
    end
  end

  // stab counts consecutive cycles the current {select, segments} pair has been seen.
  always_comb begin
    stab_d  = STW'(1);
    if ({led_dig, led_seg} == pair_q)
      stab_d = (stab_q == STW'(SETTLE)) ? stab_q : stab_q + STW'(1);
    settled = (stab_d == STW'(SETTLE)) && (stab_q != STW'(SETTLE));
    onehot  = ($countones(~led_dig) == 1);
    sel_idx = 3'd0;
    for (int i = 0; i < NDIG; i++)
      if (!led_dig[i]) sel_idx = 3'(i);
    wr = settled && onehot && (led_seg != 7'h7F);
  end

  always_comb begin
    dig_d = dig_q;
    upd_d = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      dcy_d[i] = dcy_q[i];
      if (wr && (sel_idx == 3'(i))) begin
        dcy_d[i] = DW'(DECAY);
        dig_d[i] = ~led_seg;
        if (dig_q[i] != ~led_seg) upd_d = 1'b1;
      end else if (dcy_q[i] != '0) begin
        dcy_d[i] = dcy_q[i] - DW'(1);
        if (dcy_d[i] == '0) begin
          dig_d[i] = '0;
          if (dig_q[i] != '0) upd_d = 1'b1;
        end
      end
    end
  end

  assign disp        = dig_q;
  assign disp_update = upd_q;

endmodule
